// File: rtl/mac_kbd_pkg.sv
// Shared codes and state encoding for the Mac Plus keyboard link responder.
package mac_kbd_pkg;

   localparam logic [7:0] CMD_INQUIRY = 8'h10;
   localparam logic [7:0] CMD_INSTANT = 8'h14;
   localparam logic [7:0] CMD_MODEL   = 8'h16;
   localparam logic [7:0] CMD_TEST    = 8'h36;

   localparam logic [7:0] RSP_MODEL   = 8'h0B;
   localparam logic [7:0] RSP_TEST    = 8'h7D;
   localparam logic [7:0] RSP_NULL    = 8'h7B;

   localparam logic [7:0] PFX_EXT1    = 8'h71;
   localparam logic [7:0] PFX_EXT0    = 8'h79;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX,
      ST_RELWAIT,
      ST_DECODE,
      ST_WAIT,
      ST_LOAD,
      ST_TX
   } kbd_state_e;

   // Number of protocol bytes produced by one key event {ext[1:0], break, code[6:0]}.
   function automatic logic [1:0] event_len(input logic [9:0] d);
      if (d[9])
         return 2'd3;
      else if (d[8])
         return 2'd2;
      else
         return 2'd1;
   endfunction

   // Byte to emit given how many bytes of the event remain (prefixes come first).
   function automatic logic [7:0] event_byte(input logic [1:0] left, input logic [7:0] code);
      if (left == 2'd3)
         return PFX_EXT1;
      else if (left == 2'd2)
         return PFX_EXT0;
      else
         return code;
   endfunction

endpackage

// File: rtl/kbd_byte_fifo.sv
// Synchronous 8-bit FIFO with first-word-fallthrough output and wrapping
// pointers one bit wider than the address.
module kbd_byte_fifo #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/mac_kbd_link.sv
// Keyboard-side responder for the Mac Plus keyboard link: queues key events
// as protocol bytes and serves host commands over the clocked serial line.
//
// state   | meaning
// IDLE    | clock high, line released, watching for host request (data low)
// RX      | clocking in 8 command bits from the host
// RELWAIT | waiting for the host to release the data line
// DECODE  | acting on the received command
// WAIT    | Inquiry: waiting for a queued byte or the timeout
// LOAD    | popping a queued byte (or null) into the shifter
// TX      | clocking out 8 response bits
module mac_kbd_link
   import mac_kbd_pkg::*;
#(
   parameter int T_LOW       = 1460,
   parameter int T_HIGH      = 1300,
   parameter int INQ_TIMEOUT = 2031250,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       kbd_strobe,
   input  logic [9:0] kbd_data,
   output logic       kbd_clk,
   input  logic       kbd_dat_in,
   output logic       kbd_dat_out,
   output logic       kbd_dat_oe,
   output logic       overflow
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int TMAX  = (T_LOW > T_HIGH) ? T_LOW : T_HIGH;
   localparam int PW    = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;
   localparam int TW    = ($clog2(INQ_TIMEOUT) > 0) ? $clog2(INQ_TIMEOUT) : 1;

   // ---------------- event capture and push sequencer ----------------
   logic        strobe_q;
   logic        key_evt;
   logic        seq_active;
   logic [1:0]  seq_left;
   logic [7:0]  seq_code;
   logic        pend_valid;
   logic [9:0]  pend_data;
   logic        overflow_q;
   logic        cand_valid;
   logic [9:0]  cand_data;
   logic        cand_fits;
   logic [AW:0] fifo_free;

   logic        fifo_push;
   logic        fifo_pop;
   logic [7:0]  fifo_din;
   logic [7:0]  fifo_dout;
   logic [AW:0] fifo_count;
   logic        fifo_full;
   logic        fifo_empty;

   assign key_evt    = kbd_strobe ^ strobe_q;
   assign fifo_free  = (AW+1)'(FIFO_DEPTH) - fifo_count;
   assign cand_valid = !seq_active && (pend_valid || key_evt);
   assign cand_data  = pend_valid ? pend_data : kbd_data;
   assign cand_fits  = (AW+1)'(event_len(cand_data)) <= fifo_free;
   assign fifo_push  = seq_active && !fifo_full;
   assign fifo_din   = event_byte(seq_left, seq_code);
   assign overflow   = overflow_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_q   <= kbd_strobe;
         seq_active <= 1'b0;
         seq_left   <= '0;
         seq_code   <= '0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         overflow_q <= 1'b0;
      end else begin
         strobe_q <= kbd_strobe;
         if (seq_active) begin
            seq_left <= seq_left - 2'd1;
            if (seq_left == 2'd1)
               seq_active <= 1'b0;
            if (key_evt) begin
               if (pend_valid)
                  overflow_q <= 1'b1;
               else begin
                  pend_valid <= 1'b1;
                  pend_data  <= kbd_data;
               end
            end
         end else begin
            // Space is checked for the whole event so it is never split.
            if (cand_valid) begin
               if (cand_fits) begin
                  seq_active <= 1'b1;
                  seq_left   <= event_len(cand_data);
                  seq_code   <= cand_data[7:0];
               end else begin
                  overflow_q <= 1'b1;
               end
            end
            if (pend_valid) begin
               pend_valid <= key_evt;
               pend_data  <= kbd_data;
            end
         end
      end
   end

   kbd_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // ---------------- link FSM ----------------
   kbd_state_e  state;
   kbd_state_e  state_n;
   logic        tx_load;
   logic [7:0]  tx_byte;
   logic        dat_low_q;
   logic [PW-1:0] phase_cnt;
   logic [3:0]  bit_cnt;
   logic        kbd_clk_q;
   logic        dat_out_q;
   logic [7:0]  shift_q;
   logic [TW-1:0] to_cnt;
   logic        cells_done;
   logic        in_cells;

   assign in_cells    = (state == ST_RX) || (state == ST_TX);
   assign cells_done  = kbd_clk_q && (phase_cnt == '0) && (bit_cnt == 4'd8);
   assign kbd_clk     = kbd_clk_q;
   assign kbd_dat_out = dat_out_q;
   assign kbd_dat_oe  = (state == ST_TX);

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n  = state;
      fifo_pop = 1'b0;
      tx_load  = 1'b0;
      tx_byte  = RSP_NULL;
      unique case (state)
         ST_IDLE: begin
            if (!kbd_dat_in && dat_low_q)
               state_n = ST_RX;
         end
         ST_RX: begin
            if (cells_done)
               state_n = ST_RELWAIT;
         end
         ST_RELWAIT: begin
            if (kbd_dat_in)
               state_n = ST_DECODE;
         end
         ST_DECODE: begin
            case (shift_q)
               CMD_INQUIRY: state_n = ST_WAIT;
               CMD_INSTANT: state_n = ST_LOAD;
               CMD_MODEL: begin
                  tx_load = 1'b1;
                  tx_byte = RSP_MODEL;
                  state_n = ST_TX;
               end
               CMD_TEST: begin
                  tx_load = 1'b1;
                  tx_byte = RSP_TEST;
                  state_n = ST_TX;
               end
               default: state_n = ST_IDLE;
            endcase
         end
         ST_WAIT: begin
            // On timeout LOAD finds the FIFO empty and substitutes the null reply.
            if (!fifo_empty || (to_cnt == '0))
               state_n = ST_LOAD;
         end
         ST_LOAD: begin
            tx_load = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               tx_byte  = fifo_dout;
            end
            state_n = ST_TX;
         end
         ST_TX: begin
            if (cells_done)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Bit-cell engine: the cycle entering RX/TX has the clock high with an
   // expired phase, so the first fall follows one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         dat_low_q <= 1'b0;
         phase_cnt <= '0;
         bit_cnt   <= '0;
         kbd_clk_q <= 1'b1;
         dat_out_q <= 1'b1;
         shift_q   <= '0;
         to_cnt    <= TW'(INQ_TIMEOUT - 1);
      end else begin
         dat_low_q <= ~kbd_dat_in;

         if (state != ST_WAIT)
            to_cnt <= TW'(INQ_TIMEOUT - 1);
         else if (to_cnt != '0)
            to_cnt <= to_cnt - 1'b1;

         if (in_cells) begin
            if (phase_cnt != '0) begin
               phase_cnt <= phase_cnt - 1'b1;
            end else if (kbd_clk_q) begin
               if (bit_cnt != 4'd8) begin
                  kbd_clk_q <= 1'b0;
                  phase_cnt <= PW'(T_LOW - 1);
                  if (state == ST_TX) begin
                     dat_out_q <= shift_q[7];
                     shift_q   <= {shift_q[6:0], 1'b0};
                  end
               end else begin
                  dat_out_q <= 1'b1;
               end
            end else begin
               kbd_clk_q <= 1'b1;
               phase_cnt <= PW'(T_HIGH - 1);
               bit_cnt   <= bit_cnt + 4'd1;
               if (state == ST_RX)
                  shift_q <= {shift_q[6:0], kbd_dat_in};
            end
         end else begin
            kbd_clk_q <= 1'b1;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            dat_out_q <= 1'b1;
            if (tx_load)
               shift_q <= tx_byte;
         end
      end
   end

endmodule
